// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one outstanding imem request at a time,
// buffers responses in a 2-entry queue for decode, and flushes wrong-path work on redirect.
module fetch_ctrl #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             instr_valid,
  output logic [31:0]      instr,
  output logic [WIDTH-1:0] instr_pc,
  input  logic             instr_ready
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] req_pc_q;
  logic             kill_q;
  logic [1:0]       count_q, count_d;
  logic             rd_ptr_q, wr_ptr_q;
  logic [WIDTH-1:0] q_pc_q   [2];
  logic [31:0]      q_data_q [2];

  logic             granted;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] target_pc;

  assign target_pc   = {redirect_pc[WIDTH-1:2], 2'b00};
  assign imem_req    = (state_q == ISSUE) && (count_q < 2'd2);
  assign imem_addr   = pc_q;
  assign instr_valid = (count_q != 2'd0);
  assign instr       = q_data_q[rd_ptr_q];
  assign instr_pc    = q_pc_q[rd_ptr_q];

  assign granted = imem_req && imem_gnt;
  // A killed response, or one arriving alongside a redirect, is wrong-path and never enters the queue.
  assign push    = (state_q == WAIT) && imem_rvalid && !kill_q && !redirect;
  assign pop     = instr_valid && instr_ready;

  always_comb begin
    count_d = count_q;
    if (redirect) begin
      count_d = 2'd0;
    end else begin
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      kill_q   <= 1'b0;
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        q_pc_q[i]   <= '0;
        q_data_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: state_q <= ISSUE;
        ISSUE: begin
          if (granted) begin
            req_pc_q <= pc_q;
            pc_q     <= pc_q + WIDTH'(4);
            state_q  <= WAIT;
            if (redirect) kill_q <= 1'b1;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            kill_q  <= 1'b0;
            state_q <= ISSUE;
          end else if (redirect) begin
            kill_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase

      // Redirect target overrides the sequential increment.
      if (redirect) pc_q <= target_pc;

      count_q <= count_d;
      if (redirect) begin
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
      end else begin
        if (push) begin
          q_pc_q[wr_ptr_q]   <= req_pc_q;
          q_data_q[wr_ptr_q] <= imem_rdata;
          wr_ptr_q           <= ~wr_ptr_q;
        end
        if (pop) rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: variable-latency memory model returning ~addr, a cycle table from reset,
// and hand-written redirect / wrap / async-reset sequences; transfers are checked against a scoreboard.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b1;

  always #5 clk = ~clk;

  fetch_ctrl #(.WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
  );

  // Memory: grants whenever enabled, answers after lat cycles with ~addr.
  int          lat = 1;
  bit          gnt_en = 1'b1;
  logic        mem_pend = 1'b0;
  logic [31:0] mem_addr = '0;
  int          mem_cnt = 0;

  assign imem_gnt    = imem_req && gnt_en;
  assign imem_rvalid = mem_pend && (mem_cnt == 0);
  assign imem_rdata  = ~mem_addr;

  always @(posedge clk) begin
    if (imem_rvalid) mem_pend <= 1'b0;
    if (imem_req && imem_gnt) begin
      mem_pend <= 1'b1;
      mem_addr <= imem_addr;
      mem_cnt  <= lat - 1;
    end else if (mem_pend && mem_cnt != 0) begin
      mem_cnt <= mem_cnt - 1;
    end
  end

  int          errors = 0;
  int          checks = 0;
  int          xfers  = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    bit          restart;
    bit          ready;
    bit          req;
    logic [31:0] addr;
    bit          valid;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every decode transfer must match the next expected PC, with data ~pc.
  task automatic sb_sample();
    logic [31:0] e;
    if (!rst && instr_valid && instr_ready) begin
      xfers++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL xfer: got pc=%h with nothing expected", instr_pc);
      end else begin
        e = exp_q.pop_front();
        if (instr_pc !== e || instr !== ~e) begin
          errors++;
          $display("FAIL xfer: got pc=%h instr=%h expected pc=%h instr=%h", instr_pc, instr, e, ~e);
        end else begin
          $display("xfer pc=%h instr=%h", instr_pc, instr);
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    sb_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    logic [31:0] a;
    a = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(a);
      a = a + 32'd4;
    end
  endtask

  // Leaves the bench in the IDLE cycle right after reset release.
  task automatic restart();
    rst = 1'b1;
    redirect = 1'b0;
    exp_q.delete();
    repeat (5) step();
    push_seq(32'h0, 32);
    rst = 1'b0;
  endtask

  task automatic do_redirect(input logic [31:0] t);
    redirect    = 1'b1;
    redirect_pc = t;
    step();
    redirect = 1'b0;
    exp_q.delete();
    push_seq({t[31:2], 2'b00}, 32);
  endtask

  task automatic wait_xfers(input int n, input int budget);
    int target;
    int k;
    target = xfers + n;
    k = 0;
    while (xfers < target && k < budget) begin
      step();
      k++;
    end
    checks++;
    if (xfers < target) begin
      errors++;
      $display("FAIL xfer_timeout: got %0d transfers required %0d", xfers, target);
    end
  endtask

  initial begin
    // Zero-wait memory, decode always ready.
    tbl[0]  = '{1, 1, 0, 32'h0, 0, 32'h0};
    tbl[1]  = '{0, 1, 1, 32'h0, 0, 32'h0};
    tbl[2]  = '{0, 1, 0, 32'h0, 0, 32'h0};
    tbl[3]  = '{0, 1, 1, 32'h4, 1, 32'h0};
    tbl[4]  = '{0, 1, 0, 32'h0, 0, 32'h0};
    tbl[5]  = '{0, 1, 1, 32'h8, 1, 32'h4};
    tbl[6]  = '{0, 1, 0, 32'h0, 0, 32'h0};
    tbl[7]  = '{0, 1, 1, 32'hC, 1, 32'h8};
    // Decode stalled: two entries fill, fetch stops, then drains and resumes at 0x8.
    tbl[8]  = '{1, 0, 0, 32'h0, 0, 32'h0};
    tbl[9]  = '{0, 0, 1, 32'h0, 0, 32'h0};
    tbl[10] = '{0, 0, 0, 32'h0, 0, 32'h0};
    tbl[11] = '{0, 0, 1, 32'h4, 1, 32'h0};
    tbl[12] = '{0, 0, 0, 32'h0, 1, 32'h0};
    tbl[13] = '{0, 0, 0, 32'h0, 1, 32'h0};
    tbl[14] = '{0, 0, 0, 32'h0, 1, 32'h0};
    tbl[15] = '{0, 0, 0, 32'h0, 1, 32'h0};
    tbl[16] = '{0, 1, 0, 32'h0, 1, 32'h0};
    tbl[17] = '{0, 1, 1, 32'h8, 1, 32'h4};
    tbl[18] = '{0, 1, 0, 32'h0, 0, 32'h0};
    tbl[19] = '{0, 1, 1, 32'hC, 1, 32'h8};

    restart();
    chk("reset_addr", imem_addr, 32'h0);
    chk("reset_instr", instr, 32'h0);

    for (int i = 0; i < 20; i++) begin
      if (tbl[i].restart) restart();
      instr_ready = tbl[i].ready;
      chk($sformatf("tbl%0d_req", i), {31'b0, imem_req}, {31'b0, tbl[i].req});
      if (tbl[i].req) chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_valid", i), {31'b0, instr_valid}, {31'b0, tbl[i].valid});
      if (tbl[i].valid) chk($sformatf("tbl%0d_pc", i), instr_pc, tbl[i].pc);
      step();
    end

    // Redirect in WAIT with a 3-cycle response: response discarded, refetch at 0x100.
    lat = 3;
    instr_ready = 1'b1;
    restart();
    step();
    chk("wait_rd_c1_addr", imem_addr, 32'h0);
    step();
    do_redirect(32'h103);
    chk("wait_rd_req_a", {31'b0, imem_req}, 32'h0);
    step();
    chk("wait_rd_req_b", {31'b0, imem_req}, 32'h0);
    step();
    chk("wait_rd_req_c", {31'b0, imem_req}, 32'h1);
    chk("wait_rd_addr", imem_addr, 32'h100);
    wait_xfers(2, 40);

    // Redirect coincident with the grant of 0x10.
    lat = 1;
    restart();
    do_redirect(32'h10);
    chk("coinc_req", {31'b0, imem_req}, 32'h1);
    chk("coinc_addr", imem_addr, 32'h10);
    do_redirect(32'h200);
    chk("coinc_wait_req", {31'b0, imem_req}, 32'h0);
    step();
    chk("coinc_next_req", {31'b0, imem_req}, 32'h1);
    chk("coinc_next_addr", imem_addr, 32'h200);
    chk("coinc_valid", {31'b0, instr_valid}, 32'h0);
    wait_xfers(3, 40);

    // Redirect with a full queue: head transfers, queue cleared, refill from target.
    instr_ready = 1'b0;
    restart();
    repeat (5) step();
    chk("full_valid", {31'b0, instr_valid}, 32'h1);
    chk("full_req", {31'b0, imem_req}, 32'h0);
    chk("full_pc", instr_pc, 32'h0);
    instr_ready = 1'b1;
    do_redirect(32'h300);
    chk("full_rd_valid", {31'b0, instr_valid}, 32'h0);
    chk("full_rd_req", {31'b0, imem_req}, 32'h1);
    chk("full_rd_addr", imem_addr, 32'h300);
    wait_xfers(2, 40);

    // PC wrap at the top of the address space.
    restart();
    do_redirect(32'hFFFF_FFFF);
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    step();
    step();
    chk("wrap_req", {31'b0, imem_req}, 32'h1);
    chk("wrap_addr1", imem_addr, 32'h0);
    wait_xfers(2, 40);

    // Async reset while a response is outstanding; the late response must be ignored.
    lat = 4;
    restart();
    do_redirect(32'h40);
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_req", {31'b0, imem_req}, 32'h0);
    chk("arst_addr", imem_addr, 32'h0);
    chk("arst_valid", {31'b0, instr_valid}, 32'h0);
    chk("arst_instr", instr, 32'h0);
    chk("arst_pc", instr_pc, 32'h0);
    gnt_en = 1'b0;
    step();
    rst = 1'b0;
    repeat (5) step();
    chk("late_rv_valid", {31'b0, instr_valid}, 32'h0);
    chk("late_rv_req", {31'b0, imem_req}, 32'h1);
    chk("late_rv_addr", imem_addr, 32'h0);
    gnt_en = 1'b1;
    lat = 1;
    exp_q.delete();
    push_seq(32'h0, 32);
    wait_xfers(2, 40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
